// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch-predictor update sequencer.
package bpu_pkg;

   localparam int PC_W  = 32;
   localparam int TAG_W = 27;
   localparam int IDX_W = PC_W - TAG_W;

   localparam logic [PC_W-1:0] PC_INCR = PC_W'(4);

   typedef enum logic {
      INIT,
      RUN
   } bpu_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic             valid;
   } upd_entry_t;

endpackage

// File: rtl/bpu_update_fifo.sv
// Synchronous FIFO for pending table updates; a push while full is taken only if a pop frees a slot.
module bpu_update_fifo
   import bpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = upd_entry_t
) (
   input  logic   clk_in,
   input  logic   rst_in,
   input  logic   push_in,
   input  entry_t push_data_in,
   input  logic   pop_in,
   output entry_t pop_data_out,
   output logic   full_out,
   output logic   empty_out
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates full from empty when the indices match.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   entry_t      mem_q [DEPTH];
   logic        push_ok;
   logic        pop_ok;

   assign empty_out    = (wr_ptr_q == rd_ptr_q);
   assign full_out     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok       = pop_in && !empty_out;
   assign push_ok      = push_in && (!full_out || pop_ok);
   assign pop_data_out = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d     = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which slots are live.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_in;
      end
   end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Branch-predictor table write sequencer: mispredict flush/redirect, update queue, reset invalidation sweep.
// Optional build macro BPU_CTRL_STATS_EN adds saturating mispredict and drop counters.
module bpu_update_ctrl
   import bpu_pkg::*;
#(
   parameter int PC     = PC_W,
   parameter int TAG    = TAG_W,
   parameter int QDEPTH = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              resolve_valid_in,
   input  logic [PC-1:0]     resolve_pc_in,
   input  logic              resolve_taken_in,
   input  logic [PC-1:0]     resolve_target_in,
   input  logic              pred_taken_in,
   input  logic [PC-1:0]     pred_target_in,
   output logic              flush_out,
   output logic [PC-1:0]     redirect_pc_out,
   output logic              tbl_write_out,
   output logic [PC-TAG-1:0] tbl_index_out,
   output logic [TAG-1:0]    tbl_tag_out,
   output logic [PC-1:0]     tbl_target_out,
   output logic              tbl_valid_out,
   output logic              init_busy_out
`ifdef BPU_CTRL_STATS_EN
   ,
   output logic [31:0]       mispredict_count_out,
   output logic [15:0]       drop_count_out
`endif
);

   localparam int IDX = PC - TAG;

   // The queued entry type is fixed by the package, so the widths must agree with it.
   if (PC != PC_W || TAG != TAG_W) begin : g_cfg_check
      $error("bpu_update_ctrl: PC/TAG must match bpu_pkg widths");
   end

   bpu_state_e     state_q, state_d;
   logic [IDX-1:0] sweep_q, sweep_d;
   logic           flush_q;
   logic [PC-1:0]  redirect_q, redirect_d;
   logic           tbl_write_q, tbl_write_d;
   upd_entry_t     tbl_q, tbl_d;
   logic           busy_q;

   logic           mispredict;
   logic           pop;
   logic           push_accept;
   upd_entry_t     push_entry;
   upd_entry_t     head_entry;
   logic           fifo_full;
   logic           fifo_empty;

   assign mispredict = resolve_valid_in &&
                       ((resolve_taken_in != pred_taken_in) ||
                        (resolve_taken_in && (resolve_target_in != pred_target_in)));
   assign redirect_d = mispredict ? (resolve_taken_in ? resolve_target_in : resolve_pc_in + PC_INCR)
                                  : redirect_q;

   assign push_entry = '{index:  resolve_pc_in[IDX-1:0],
                         tag:    resolve_pc_in[PC-1:IDX],
                         target: resolve_taken_in ? resolve_target_in : '0,
                         valid:  resolve_taken_in};

   // The queue only drains once the sweep has finished; a full queue takes a push only alongside a pop.
   assign pop         = (state_q == RUN) && !fifo_empty;
   assign push_accept = mispredict && (!fifo_full || pop);

   bpu_update_fifo #(
      .DEPTH   (QDEPTH),
      .entry_t (upd_entry_t)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (push_accept),
      .push_data_in (push_entry),
      .pop_in       (pop),
      .pop_data_out (head_entry),
      .full_out     (fifo_full),
      .empty_out    (fifo_empty)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      tbl_write_d = 1'b0;
      tbl_d       = tbl_q;
      unique case (state_q)
         INIT: begin
            tbl_write_d = 1'b1;
            tbl_d       = '{index: sweep_q, tag: '0, target: '0, valid: 1'b0};
            sweep_d     = sweep_q + 1'b1;
            if (sweep_q == '1) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (pop) begin
               tbl_write_d = 1'b1;
               tbl_d       = head_entry;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= INIT;
         sweep_q     <= '0;
         flush_q     <= 1'b0;
         redirect_q  <= '0;
         tbl_write_q <= 1'b0;
         tbl_q       <= '0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         flush_q     <= mispredict;
         redirect_q  <= redirect_d;
         tbl_write_q <= tbl_write_d;
         tbl_q       <= tbl_d;
         busy_q      <= (state_q == INIT);
      end
   end

   assign flush_out       = flush_q;
   assign redirect_pc_out = redirect_q;
   assign tbl_write_out   = tbl_write_q;
   assign tbl_index_out   = tbl_q.index;
   assign tbl_tag_out     = tbl_q.tag;
   assign tbl_target_out  = tbl_q.target;
   assign tbl_valid_out   = tbl_q.valid;
   assign init_busy_out   = busy_q;

`ifdef BPU_CTRL_STATS_EN
   logic [31:0] mis_cnt_q;
   logic [15:0] drop_cnt_q;
   logic        drop;

   assign drop = mispredict && !push_accept;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mis_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_q <= mis_cnt_q + 1'b1;
         end
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign mispredict_count_out = mis_cnt_q;
   assign drop_count_out       = drop_cnt_q;
`endif

endmodule
